// File: rtl/tx_pam4_channel_gen.sv
// PRBS9 -> Gray PAM-4 -> programmable channel FIR stimulus source for the CMA equalizer.
// Optional additive noise stage compiled in with `define TX_NOISE_EN.
module tx_pam4_channel_gen #(
    parameter int         NB_OUT       = 18,
    parameter int         NBF_OUT      = 15,
    parameter int         CH_LEN       = 5,
    parameter int         NB_CH_COEFF  = 16,
    parameter int         NBF_CH_COEFF = 14,
    parameter logic [8:0] PRBS_SEED    = 9'h1FF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic                      i_coeff_we,
    input  logic [$clog2(CH_LEN)-1:0] i_coeff_addr,
    input  logic [NB_CH_COEFF-1:0]    i_coeff_data,
    output logic [NB_OUT-1:0]         o_sample,
    output logic                      o_valid,
    output logic [1:0]                o_symbol,
    output logic                      o_sat
);

    localparam int NB_ADDR = $clog2(CH_LEN);
    localparam int NB_PROD = NB_OUT + NB_CH_COEFF;
    localparam int NB_SUM  = NB_PROD + NB_ADDR;
    localparam int NB_HEAD = NB_SUM - NB_OUT + 1;

    localparam logic [8:0]                    SEED_EFF  = (PRBS_SEED == 9'h000) ? 9'h1FF : PRBS_SEED;
    localparam logic signed [NB_OUT-1:0]      LVL_HI    = NB_OUT'(32'sd3 << (NBF_OUT - 2));
    localparam logic signed [NB_OUT-1:0]      LVL_LO    = NB_OUT'(32'sd1 << (NBF_OUT - 2));
    localparam logic signed [NB_CH_COEFF-1:0] COEFF_ONE = NB_CH_COEFF'(32'sd1 << NBF_CH_COEFF);
    localparam logic signed [NB_SUM-1:0]      RND_HALF  = {{(NB_SUM-1){1'b0}}, 1'b1} << (NBF_CH_COEFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [8:0] prbs9_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    function automatic logic signed [NB_OUT-1:0] gray_map(input logic [1:0] g);
        logic signed [NB_OUT-1:0] v;
        case (g)
            2'b00:   v = -LVL_HI;
            2'b01:   v = -LVL_LO;
            2'b11:   v = LVL_LO;
            2'b10:   v = LVL_HI;
            default: v = {NB_OUT{1'b0}};
        endcase
        return v;
    endfunction

    state_t                          state_r, state_s;
    logic [NB_ADDR-1:0]              fill_cnt_r;
    logic [8:0]                      lfsr_r, lfsr_mid_s, lfsr_next_s;
    logic [1:0]                      sym_bits_s, sym0_r;
    logic signed [NB_OUT-1:0]        x_r     [CH_LEN];
    logic signed [NB_CH_COEFF-1:0]   coeff_r [CH_LEN];
    logic signed [NB_PROD-1:0]       prod_s  [CH_LEN];
    logic signed [NB_SUM-1:0]        sum_s, rnd_s, pre_sat_s;
    logic [NB_OUT-1:0]               sat_val_s;
    logic                            sat_flag_s;

    // Two LFSR steps per symbol: first new bit is the Gray MSB
    assign lfsr_mid_s  = prbs9_step(lfsr_r);
    assign lfsr_next_s = prbs9_step(lfsr_mid_s);
    assign sym_bits_s  = {lfsr_mid_s[0], lfsr_next_s[0]};

    // State register and fill counter
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= IDLE;
            fill_cnt_r <= {NB_ADDR{1'b0}};
        end else if (i_en) begin
            state_r <= state_s;
            if (state_r == FILL) begin
                fill_cnt_r <= fill_cnt_r + {{(NB_ADDR-1){1'b0}}, 1'b1};
            end else begin
                fill_cnt_r <= {NB_ADDR{1'b0}};
            end
        end
    end

    // Next-state logic; RUN follows CH_LEN-1 enabled edges spent in FILL
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_en) state_s = FILL;
                else      state_s = IDLE;
            end
            FILL: begin
                if (i_en && (fill_cnt_r == NB_ADDR'(CH_LEN - 2))) state_s = RUN;
                else                                               state_s = FILL;
            end
            RUN:     state_s = RUN;
            default: state_s = IDLE;
        endcase
    end

    // Symbol source and channel delay line advance together on enabled edges
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lfsr_r <= SEED_EFF;
            sym0_r <= 2'b00;
            for (int k = 0; k < CH_LEN; k++) x_r[k] <= {NB_OUT{1'b0}};
        end else if (i_en) begin
            lfsr_r <= lfsr_next_s;
            sym0_r <= sym_bits_s;
            x_r[0] <= gray_map(sym_bits_s);
            for (int k = 1; k < CH_LEN; k++) x_r[k] <= x_r[k-1];
        end
    end

    // Coefficient bank; writes land regardless of enable, out-of-range addresses match nothing
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            coeff_r[0] <= COEFF_ONE;
            for (int k = 1; k < CH_LEN; k++) coeff_r[k] <= {NB_CH_COEFF{1'b0}};
        end else begin
            for (int k = 0; k < CH_LEN; k++) begin
                if (i_coeff_we && (i_coeff_addr == NB_ADDR'(k))) coeff_r[k] <= i_coeff_data;
            end
        end
    end

    // Full-precision FIR sum, then round-half-up back to the output LSB
    always_comb begin
        sum_s = {NB_SUM{1'b0}};
        for (int k = 0; k < CH_LEN; k++) begin
            prod_s[k] = $signed({{NB_CH_COEFF{x_r[k][NB_OUT-1]}}, x_r[k]})
                      * $signed({{NB_OUT{coeff_r[k][NB_CH_COEFF-1]}}, coeff_r[k]});
            sum_s = sum_s + $signed({{NB_ADDR{prod_s[k][NB_PROD-1]}}, prod_s[k]});
        end
        rnd_s = (sum_s + RND_HALF) >>> NBF_CH_COEFF;
    end

`ifdef TX_NOISE_EN
    logic [14:0] noise_r;

    // PRBS15 noise source, one step per enabled cycle
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            noise_r <= 15'h7FFF;
        end else if (i_en) begin
            noise_r <= {noise_r[13:0], noise_r[14] ^ noise_r[13]};
        end
    end

    assign pre_sat_s = rnd_s + $signed({{(NB_SUM-4){noise_r[3]}}, noise_r[3:0]});
`else
    assign pre_sat_s = rnd_s;
`endif

    // Saturate when the bits above the output sign are not a pure sign extension
    always_comb begin
        sat_val_s  = pre_sat_s[NB_OUT-1:0];
        sat_flag_s = 1'b0;
        if ((pre_sat_s[NB_SUM-1:NB_OUT-1] == {NB_HEAD{1'b0}}) ||
            (pre_sat_s[NB_SUM-1:NB_OUT-1] == {NB_HEAD{1'b1}})) begin
            sat_val_s  = pre_sat_s[NB_OUT-1:0];
            sat_flag_s = 1'b0;
        end else if (pre_sat_s[NB_SUM-1]) begin
            sat_val_s  = {1'b1, {(NB_OUT-1){1'b0}}};
            sat_flag_s = 1'b1;
        end else begin
            sat_val_s  = {1'b0, {(NB_OUT-1){1'b1}}};
            sat_flag_s = 1'b1;
        end
    end

    // Output registers; sample and symbol hold while stalled or filling
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_sample <= {NB_OUT{1'b0}};
            o_valid  <= 1'b0;
            o_symbol <= 2'b00;
            o_sat    <= 1'b0;
        end else if (i_en && (state_r == RUN)) begin
            o_sample <= sat_val_s;
            o_valid  <= 1'b1;
            o_symbol <= sym0_r;
            o_sat    <= sat_flag_s;
        end else begin
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_pam4_channel_gen.sv
// Scoreboard bench for tx_pam4_channel_gen: a sequence-level reference model predicts every
// valid sample; a negedge monitor pops and compares whatever the DUT presents.
module tb_tx_pam4_channel_gen;

    localparam int NB_OUT  = 18;
    localparam int CH_LEN  = 5;
    localparam int NB_ADDR = $clog2(CH_LEN);
    localparam int MAXV    = 131071;
    localparam int MINV    = -131072;
`ifdef TX_NOISE_EN
    localparam int TOL = 8;
`else
    localparam int TOL = 0;
`endif

    logic               i_clock;
    logic               i_reset;
    logic               i_en;
    logic               i_coeff_we;
    logic [NB_ADDR-1:0] i_coeff_addr;
    logic [15:0]        i_coeff_data;
    logic [NB_OUT-1:0]  o_sample;
    logic               o_valid;
    logic [1:0]         o_symbol;
    logic               o_sat;

    tx_pam4_channel_gen dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_en         (i_en),
        .i_coeff_we   (i_coeff_we),
        .i_coeff_addr (i_coeff_addr),
        .i_coeff_data (i_coeff_data),
        .o_sample     (o_sample),
        .o_valid      (o_valid),
        .o_symbol     (o_symbol),
        .o_sat        (o_sat)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        int         sample;
        int         rnd;
        logic [1:0] sym;
        bit         sat;
    } exp_t;

    exp_t       exp_q[$];
    int         h_m [CH_LEN];
    bit         hist[$];
    int         sym_val[$];
    logic [1:0] sym_gray[$];
    int         edges;
    int         n_cmp;
    int         n_bad;
    bit         have_last;
    int         last_sample;
    logic [1:0] last_sym;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        if (a >= 0) return a / b;
        else        return -((-a + b - 1) / b);
    endfunction

    function automatic int level(input logic [1:0] g);
        case (g)
            2'b00:   return -24576;
            2'b01:   return -8192;
            2'b11:   return 8192;
            default: return 24576;
        endcase
    endfunction

    // PRBS9 as a bit recurrence b[n] = b[n-9] ^ b[n-5] over the last nine bits
    function automatic bit next_bit();
        bit nb;
        nb = hist[0] ^ hist[4];
        hist.push_back(nb);
        void'(hist.pop_front());
        return nb;
    endfunction

    task automatic model_reset();
        logic [8:0] sd;
        sd = 9'h1FF;
        hist.delete();
        for (int i = 8; i >= 0; i--) hist.push_back(sd[i]);
        for (int k = 0; k < CH_LEN; k++) h_m[k] = 0;
        h_m[0] = 16384;
        sym_val.delete();
        sym_gray.delete();
        exp_q.delete();
        edges = 0;
    endtask

    task automatic model_edge(input bit en, input bit we, input int addr, input int data);
        logic [1:0] g;
        longint     acc;
        int         n;
        exp_t       e;
        if (en) begin
            edges++;
            g[1] = next_bit();
            g[0] = next_bit();
            sym_gray.push_back(g);
            sym_val.push_back(level(g));
            if (edges >= CH_LEN + 1) begin
                n   = sym_val.size();
                acc = 0;
                for (int k = 0; k < CH_LEN; k++) acc += longint'(h_m[k]) * sym_val[n-2-k];
                e.rnd    = int'(fdiv(acc + 8192, 16384));
                e.sat    = (e.rnd > MAXV) || (e.rnd < MINV);
                e.sample = (e.rnd > MAXV) ? MAXV : ((e.rnd < MINV) ? MINV : e.rnd);
                e.sym    = sym_gray[n-2];
                exp_q.push_back(e);
            end
        end
        if (we && addr >= 0 && addr < CH_LEN) h_m[addr] = data;
    endtask

    task automatic cyc(input bit en, input bit we, input int addr, input int data);
        i_en         = en;
        i_coeff_we   = we;
        i_coeff_addr = addr[NB_ADDR-1:0];
        i_coeff_data = data[15:0];
        @(posedge i_clock);
        model_edge(en, we, addr, data);
        #1;
        i_coeff_we = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_sample"}, int'(o_sample), 0);
        chk({tag, "_valid"},  int'(o_valid),  0);
        chk({tag, "_symbol"}, int'(o_symbol), 0);
        chk({tag, "_sat"},    int'(o_sat),    0);
    endtask

    task automatic do_reset(input string tag);
        i_reset = 1'b0;
        #1;
        reset_checks(tag);
        model_reset();
        have_last = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        bit en, we;
        int addr, data;
        for (int i = 0; i < cycles; i++) begin
            en   = ($urandom_range(0, 99) < 85);
            we   = ($urandom_range(0, 99) < 10);
            addr = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) data = $urandom_range(0, 65535) - 32768;
            else                           data = $urandom_range(0, 16384) - 8192;
            cyc(en, we, addr, data);
        end
    endtask

    // Monitor: compare every presented sample against the head of the scoreboard
    initial begin
        exp_t e;
        int   diff;
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e    = exp_q.pop_front();
                        diff = int'($signed(o_sample)) - e.sample;
                        if (diff < 0) diff = -diff;
                        n_cmp++;
                        if (diff > TOL) begin
                            n_bad++;
                            $display("FAIL sample: got %0d expected %0d (tol %0d) at %0t",
                                     $signed(o_sample), e.sample, TOL, $time);
                        end
                        chk("symbol", int'(o_symbol), int'(e.sym));
                        if (TOL == 0 || e.rnd > MAXV + 8 || e.rnd < MINV - 8 ||
                            (e.rnd < MAXV - 8 && e.rnd > MINV + 8))
                            chk("sat", int'(o_sat), int'(e.sat));
                    end
                    last_sample = int'($signed(o_sample));
                    last_sym    = o_symbol;
                    have_last   = 1'b1;
                end else begin
                    chk("sat_idle", int'(o_sat), 0);
                    if (have_last) begin
                        chk("hold_sample", int'($signed(o_sample)), last_sample);
                        chk("hold_symbol", int'(o_symbol), int'(last_sym));
                    end
                end
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        have_last    = 1'b0;
        i_reset      = 1'b0;
        i_en         = 1'b0;
        i_coeff_we   = 1'b0;
        i_coeff_addr = '0;
        i_coeff_data = '0;
        model_reset();
        #3;
        reset_checks("por");
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b1;

        // identity channel, then h[1] = 0.5
        repeat (40) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1, 8192);
        repeat (30) cyc(1'b1, 1'b0, 0, 0);

        // all taps 1.0, then near 2.0, then -2.0 written during a stall
        for (int k = 0; k < CH_LEN; k++) cyc(1'b1, 1'b1, k, 16384);
        repeat (40) cyc(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < CH_LEN; k++) cyc(1'b1, 1'b1, k, 32767);
        repeat (60) cyc(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < CH_LEN; k++) cyc(1'b0, 1'b1, k, -32768);
        repeat (60) cyc(1'b1, 1'b0, 0, 0);

        // back to identity, 3-cycle stall in RUN, out-of-range address write
        cyc(1'b1, 1'b1, 0, 16384);
        for (int k = 1; k < CH_LEN; k++) cyc(1'b1, 1'b1, k, 0);
        repeat (10) cyc(1'b1, 1'b0, 0, 0);
        repeat (3) cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 6, 32767);
        repeat (20) cyc(1'b1, 1'b0, 0, 0);

        random_phase(500);

        // reset in RUN; sequence must restart from the seed with default taps
        repeat (20) cyc(1'b1, 1'b0, 0, 0);
        do_reset("midrun");
        repeat (40) cyc(1'b1, 1'b0, 0, 0);
        random_phase(200);

        repeat (2) cyc(1'b0, 1'b0, 0, 0);
        chk("pending_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
